retire_trace_emitter: RTL and testbench



---
 rtl/trace_pkg.sv | 44 ++++
 rtl/trace_if.sv | 22 ++
 rtl/trace_fifo.sv | 45 ++++
 rtl/retire_trace_emitter.sv | 170 +++++++++++++++++
 tb/tb_retire_trace_emitter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the retirement trace emitter: record kinds,
// per-cycle event mask layout and small mask helpers.
package trace_pkg;

   // Record type carried on out_kind.
   typedef enum logic [1:0] {
      KIND_REG   = 2'd0,
      KIND_LOAD  = 2'd1,
      KIND_STORE = 2'd2,
      KIND_HALT  = 2'd3
   } kind_e;

   // Serialiser states.
   typedef enum logic {
      S_IDLE = 1'b0,
      S_EMIT = 1'b1
   } state_e;

   // Event mask layout; bit order is also the emission order.
   localparam int MASK_W    = 4;
   localparam int DST_W     = 4;
   localparam int BIT_REG   = 0;
   localparam int BIT_LOAD  = 1;
   localparam int BIT_STORE = 2;
   localparam int BIT_HALT  = 3;

   typedef logic [MASK_W-1:0] mask_t;

   // Isolate the lowest set bit (one-hot result, zero for an empty mask).
   function automatic mask_t lowestBit(mask_t m);
      return m & (~m + mask_t'(1));
   endfunction

   // Map a one-hot mask bit to its record kind.
   function automatic kind_e maskKind(mask_t oneHot);
      kind_e k;
      k = KIND_REG;
      if (oneHot[BIT_LOAD])  k = KIND_LOAD;
      if (oneHot[BIT_STORE]) k = KIND_STORE;
      if (oneHot[BIT_HALT])  k = KIND_HALT;
      return k;
   endfunction

endpackage

// File: rtl/trace_if.sv
// Trace record stream: one typed record per valid/ready handshake.
interface trace_if #(
   parameter int DATA_W = 16
) ();
   import trace_pkg::*;

   logic              out_valid;
   logic              out_ready;
   kind_e             out_kind;
   logic [DATA_W-1:0] out_a;
   logic [DATA_W-1:0] out_b;

   modport master (
      output out_valid, out_kind, out_a, out_b,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_kind, out_a, out_b,
      output out_ready
   );
endinterface

// File: rtl/trace_fifo.sv
// Single-clock FIFO for cycle entries. Pointers are log2(DEPTH) bits wide
// with one slot kept free to tell full from empty, so it holds DEPTH-1
// entries; together with the serialiser's holding register the emitter
// buffers DEPTH cycles in total.
module trace_fifo #(
   parameter int WIDTH = 72,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;

   assign empty = (wrPtr == rdPtr);
   assign full  = ((wrPtr + 1'b1) == rdPtr);
   assign dout  = mem[rdPtr];

   // Storage write; the caller never pushes into a full FIFO.
   // NOTE: storage is not reset -- empty/full come from the pointers, so stale data is never observed.
   always_ff @(posedge clk) begin
      if (push) mem[wrPtr] <= din;
   end

   // Pointer update with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (push && !full) wrPtr <= wrPtr + 1'b1;
         if (pop && !empty) rdPtr <= rdPtr + 1'b1;
      end
   end
endmodule

// File: rtl/retire_trace_emitter.sv
// Retirement trace emitter: captures commit-side events each cycle into a
// FIFO of cycle entries and serialises them as typed records on trc.
module retire_trace_emitter
   import trace_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_we,
   input  logic [DST_W-1:0]  reg_dst,
   input  logic [DATA_W-1:0] reg_data,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [DATA_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              hlt,
   trace_if.master           trc,
   output logic              overflow,
   output logic              done
);
   // One buffered commit cycle.
   typedef struct packed {
      mask_t             mask;
      logic [DST_W-1:0]  dst;
      logic [DATA_W-1:0] regData;
      logic [DATA_W-1:0] memAddr;
      logic [DATA_W-1:0] memRdata;
      logic [DATA_W-1:0] memWdata;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   state_e            state;
   logic              captureEn;
   logic [DATA_W-1:0] cycleCount;
   logic [DATA_W-1:0] instCount;
   entry_t            holdEntry;
   mask_t             holdMask;   // bits still to emit, including the one on the bus

   mask_t             capMask;
   entry_t            capEntry;
   logic              fifoPush;
   logic              fifoPop;
   logic              fifoFull;
   logic              fifoEmpty;
   entry_t            fifoDout;

   logic              handshake;
   logic              haltAccepted;
   mask_t             restMask;
   entry_t            srcEntry;
   mask_t             srcMask;
   kind_e             srcKind;
   logic [DATA_W-1:0] srcA;
   logic [DATA_W-1:0] srcB;

   assign capMask  = {hlt, mem_wr, mem_rd, reg_we};
   assign capEntry = '{mask: capMask, dst: reg_dst, regData: reg_data,
                       memAddr: mem_addr, memRdata: mem_rdata, memWdata: mem_wdata};
   assign fifoPush = captureEn && (capMask != '0) && !fifoFull;

   trace_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifoPush),
      .pop   (fifoPop),
      .din   (capEntry),
      .dout  (fifoDout),
      .full  (fifoFull),
      .empty (fifoEmpty)
   );

   // Select the next record: a fresh FIFO entry on a pop, otherwise the
   // remaining bits of the held entry.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      handshake    = trc.out_valid && trc.out_ready;
      haltAccepted = handshake && (trc.out_kind == KIND_HALT);
      restMask     = holdMask & ~lowestBit(holdMask);
      fifoPop      = 1'b0;
      if (state == S_IDLE)
         fifoPop = !fifoEmpty && !done;
      else if (handshake && restMask == '0 && !haltAccepted)
         fifoPop = !fifoEmpty;
      srcEntry = fifoPop ? fifoDout : holdEntry;
      srcMask  = fifoPop ? fifoDout.mask : restMask;
      srcKind  = maskKind(lowestBit(srcMask));
      srcA     = '0;
      srcB     = '0;
      case (srcKind)
         KIND_REG:   begin srcA = DATA_W'(srcEntry.dst); srcB = srcEntry.regData;  end
         KIND_LOAD:  begin srcA = srcEntry.memAddr;      srcB = srcEntry.memRdata; end
         KIND_STORE: begin srcA = srcEntry.memAddr;      srcB = srcEntry.memWdata; end
         KIND_HALT:  begin srcA = instCount;             srcB = cycleCount;        end
         default:    ;
      endcase
   end

   // Capture side: counters, overflow flag and halt-driven capture disable.
   always_ff @(posedge clk) begin
      if (rst) begin
         captureEn  <= 1'b1;
         cycleCount <= '0;
         instCount  <= '0;
         overflow   <= 1'b0;
      end else if (captureEn) begin
         cycleCount <= cycleCount + 1'b1;
         if (hlt || reg_we || mem_wr) instCount <= instCount + 1'b1;
         if (capMask != '0) begin
            if (fifoFull) overflow  <= 1'b1;
            else if (hlt) captureEn <= 1'b0;
         end
      end
   end

   // Serialiser FSM with registered record outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         holdEntry     <= '0;
         holdMask      <= '0;
         done          <= 1'b0;
         trc.out_valid <= 1'b0;
         trc.out_kind  <= KIND_REG;
         trc.out_a     <= '0;
         trc.out_b     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (fifoPop) begin
                  holdEntry     <= fifoDout;
                  holdMask      <= srcMask;
                  trc.out_valid <= 1'b1;
                  trc.out_kind  <= srcKind;
                  trc.out_a     <= srcA;
                  trc.out_b     <= srcB;
                  state         <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (haltAccepted) begin
                  done          <= 1'b1;
                  trc.out_valid <= 1'b0;
                  holdMask      <= '0;
                  state         <= S_IDLE;
               end else if (handshake) begin
                  if (restMask != '0 || fifoPop) begin
                     if (fifoPop) holdEntry <= fifoDout;
                     holdMask     <= srcMask;
                     trc.out_kind <= srcKind;
                     trc.out_a    <= srcA;
                     trc.out_b    <= srcB;
                  end else begin
                     trc.out_valid <= 1'b0;
                     holdMask      <= '0;
                     state         <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_retire_trace_emitter.sv
// Self-checking bench for retire_trace_emitter: a small behavioural model
// pushes expected records when stimulus is driven; a monitor pops and
// compares them on every accepted record.
module tb_retire_trace_emitter;
   import trace_pkg::*;

   typedef struct {
      logic [1:0]  kind;
      logic [15:0] a;
      logic [15:0] b;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        reg_we = 1'b0;
   logic [3:0]  reg_dst = '0;
   logic [15:0] reg_data = '0;
   logic        mem_rd = 1'b0;
   logic        mem_wr = 1'b0;
   logic [15:0] mem_addr = '0;
   logic [15:0] mem_rdata = '0;
   logic [15:0] mem_wdata = '0;
   logic        hlt = 1'b0;
   logic        overflow;
   logic        done;

   int   errors = 0;
   int   checks = 0;
   int   recCount = 0;
   rec_t expQ[$];

   logic        mCapEn = 1'b1;
   logic [15:0] mCycle = '0;
   logic [15:0] mInst = '0;

   trace_if #(.DATA_W(16)) trc ();

   retire_trace_emitter #(.DEPTH(8), .DATA_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .reg_we    (reg_we),
      .reg_dst   (reg_dst),
      .reg_data  (reg_data),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_wdata (mem_wdata),
      .hlt       (hlt),
      .trc       (trc),
      .overflow  (overflow),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Accepted records are compared mid-cycle against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && trc.out_valid && trc.out_ready) begin
         rec_t e;
         recCount++;
         if (expQ.size() == 0) begin
            check("unexpected_record", 32'(trc.out_kind), 32'hFFFF_FFFF);
         end else begin
            e = expQ.pop_front();
            check("rec_kind", 32'(trc.out_kind), 32'(e.kind));
            check("rec_a", 32'(trc.out_a), 32'(e.a));
            check("rec_b", 32'(trc.out_b), 32'(e.b));
         end
      end
   end

   function automatic rec_t mkRec(input logic [1:0] k, input logic [15:0] a, input logic [15:0] b);
      rec_t r;
      r.kind = k; r.a = a; r.b = b;
      return r;
   endfunction

   // Drive one cycle of commit events; keep=0 marks an entry the test expects to be dropped.
   task automatic step(input logic we, input logic [3:0] dst, input logic [15:0] data,
                       input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] rdata, input logic [15:0] wdata,
                       input logic h, input logic keep);
      reg_we = we; reg_dst = dst; reg_data = data;
      mem_rd = rd; mem_wr = wr; mem_addr = addr;
      mem_rdata = rdata; mem_wdata = wdata; hlt = h;
      if (mCapEn) begin
         mCycle++;
         if (h || we || wr) mInst++;
         if ((h || wr || rd || we) && keep) begin
            if (we) expQ.push_back(mkRec(2'd0, {12'h000, dst}, data));
            if (rd) expQ.push_back(mkRec(2'd1, addr, rdata));
            if (wr) expQ.push_back(mkRec(2'd2, addr, wdata));
            if (h) begin
               expQ.push_back(mkRec(2'd3, mInst, mCycle));
               mCapEn = 1'b0;
            end
         end
      end
      @(posedge clk); #1;
      reg_we = 1'b0; reg_dst = '0; reg_data = '0; mem_rd = 1'b0; mem_wr = 1'b0;
      mem_addr = '0; mem_rdata = '0; mem_wdata = '0; hlt = 1'b0;
   endtask

   task automatic idle();
      step(0, 4'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 1);
   endtask

   task automatic regWrite(input logic [3:0] dst, input logic [15:0] data, input logic keep);
      step(1, dst, data, 0, 0, 16'h0, 16'h0, 16'h0, 0, keep);
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      expQ.delete();
      mCapEn = 1'b1; mCycle = '0; mInst = '0;
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while (expQ.size() != 0 && n < budget) begin
         idle();
         n++;
      end
      check(tag, 32'(expQ.size()), 32'd0);
      repeat (3) idle();
   endtask

   task automatic checkRec(input string tag, input logic [1:0] k, input logic [15:0] a, input logic [15:0] b);
      check({tag, "_valid"}, 32'(trc.out_valid), 32'd1);
      check({tag, "_kind"}, 32'(trc.out_kind), 32'(k));
      check({tag, "_a"}, 32'(trc.out_a), 32'(a));
      check({tag, "_b"}, 32'(trc.out_b), 32'(b));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      trc.out_ready = 1'b0;
      @(posedge clk); #1;

      // Reset state.
      doReset();
      check("rst_valid", 32'(trc.out_valid), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_kind", 32'(trc.out_kind), 32'd0);
      check("rst_a", 32'(trc.out_a), 32'd0);
      check("rst_b", 32'(trc.out_b), 32'd0);

      // Single register write: valid for exactly one cycle, two edges after capture.
      trc.out_ready = 1'b1;
      regWrite(4'h3, 16'h00A5, 1);
      check("single_valid_n", 32'(trc.out_valid), 32'd0);
      idle();
      checkRec("single", 2'd0, 16'h0003, 16'h00A5);
      idle();
      check("single_valid_n2", 32'(trc.out_valid), 32'd0);
      drain("single_drain", 10);

      // Multi-event cycle: REG then STORE back to back.
      step(1, 4'h2, 16'h1111, 0, 1, 16'h0040, 16'h0, 16'hBEEF, 0, 1);
      idle();
      checkRec("multi_reg", 2'd0, 16'h0002, 16'h1111);
      idle();
      checkRec("multi_store", 2'd2, 16'h0040, 16'hBEEF);
      idle();
      check("multi_valid_end", 32'(trc.out_valid), 32'd0);
      drain("multi_drain", 10);

      // Backpressure: record holds steady, accepted once.
      trc.out_ready = 1'b0;
      base = recCount;
      step(0, 4'h0, 16'h0, 1, 0, 16'h0010, 16'h7777, 16'h0, 0, 1);
      idle();
      for (int i = 0; i < 5; i++) begin
         checkRec("bp_hold", 2'd1, 16'h0010, 16'h7777);
         idle();
      end
      trc.out_ready = 1'b1;
      idle();
      check("bp_valid_after", 32'(trc.out_valid), 32'd0);
      drain("bp_drain", 10);
      check("bp_count", 32'(recCount - base), 32'd1);

      // Overflow: 11 writes with the consumer stalled, first 8 survive.
      doReset();
      trc.out_ready = 1'b0;
      base = recCount;
      for (int i = 0; i < 11; i++)
         regWrite(4'(i), 16'h0100 + 16'(i), (i < 8));
      check("ovf_flag", 32'(overflow), 32'd1);
      trc.out_ready = 1'b1;
      drain("ovf_drain", 40);
      check("ovf_count", 32'(recCount - base), 32'd8);
      check("ovf_sticky", 32'(overflow), 32'd1);

      // Halt: three writes, halt in cycle 6, later writes ignored.
      doReset();
      base = recCount;
      regWrite(4'h1, 16'h0001, 1);
      regWrite(4'h2, 16'h0002, 1);
      regWrite(4'h3, 16'h0003, 1);
      idle();
      idle();
      step(0, 4'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 1, 1);
      for (int i = 0; i < 3; i++) regWrite(4'h9, 16'hDEAD, 1);
      drain("halt_drain", 20);
      check("halt_done", 32'(done), 32'd1);
      check("halt_count", 32'(recCount - base), 32'd4);
      check("halt_valid_after", 32'(trc.out_valid), 32'd0);

      // Reset mid-stream with 4 entries buffered.
      doReset();
      trc.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) regWrite(4'(i + 4), 16'h0200 + 16'(i), 1);
      check("mid_valid_before", 32'(trc.out_valid), 32'd1);
      doReset();
      check("mid_valid", 32'(trc.out_valid), 32'd0);
      check("mid_overflow", 32'(overflow), 32'd0);
      check("mid_done", 32'(done), 32'd0);
      trc.out_ready = 1'b1;
      step(0, 4'h0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 1, 1);
      idle();
      checkRec("mid_halt", 2'd3, 16'h0001, 16'h0001);
      drain("mid_drain", 10);
      check("mid_done_end", 32'(done), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
